tick_countdown: RTL

Loadable down-counting timer that consumes the single-cycle `tick` strobes produced by the `tick_timer` prescaler chain. It counts a programmed number of ticks, then raises a one-cycle `expired` pulse. It supports pause/resume, abort-to-preset and optional auto-reload for periodic events. It sits between a `tick_timer` and control logic that needs "N ticks elapsed" events (debounce windows, display refresh, timeouts).

---
 rtl/tick_countdown.sv | 130 +++++++++++++
 1 files changed

// File: rtl/tick_countdown.sv
// tick_countdown: loadable down-counting timer driven by single-cycle tick strobes.
// Counts a programmed number of ticks, then raises a one-cycle expired pulse.
// Supports pause/resume, abort-to-preset and optional auto-reload.
module tick_countdown #(
    parameter int unsigned MAX_COUNT = 99,
    parameter int unsigned NBITS     = $clog2(MAX_COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             load,
    input  logic [NBITS-1:0] load_data,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             reload_en,
    output logic [NBITS-1:0] remaining,
    output logic             running,
    output logic             paused,
    output logic             done,
    output logic             expired
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [NBITS-1:0] MaxVal = NBITS'(MAX_COUNT);
    localparam logic [NBITS-1:0] One    = NBITS'(1);

    state_e           state_q, state_d;
    logic [NBITS-1:0] preset_q, preset_d;
    logic [NBITS-1:0] remaining_q, remaining_d;
    logic             expired_q, expired_d;
    logic             running_q, paused_q, done_q;
    logic [NBITS-1:0] load_sat_c;

    // Saturate the programmed count to MAX_COUNT
    always_comb begin
        load_sat_c = (load_data > MaxVal) ? MaxVal : load_data;
    end

    // Next-state logic in command priority order: clear > load > start/stop > tick
    always_comb begin
        state_d     = state_q;
        preset_d    = preset_q;
        remaining_d = remaining_q;
        expired_d   = 1'b0;

        if (clear) begin
            state_d     = S_IDLE;
            remaining_d = preset_q;
        end else if (load && (state_q != S_RUN)) begin
            preset_d    = load_sat_c;
            remaining_d = load_sat_c;
            state_d     = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && (remaining_q != '0)) begin
                        state_d = S_RUN;
                    end
                end
                S_PAUSE: begin
                    if (start) begin
                        state_d = S_RUN;
                    end
                end
                S_DONE: begin
                    if (start && (preset_q != '0)) begin
                        state_d     = S_RUN;
                        remaining_d = preset_q;
                    end
                end
                S_RUN: begin
                    if (tick && (remaining_q <= One)) begin
                        // Terminal tick: pulse, then reload or finish
                        expired_d = 1'b1;
                        if (reload_en) begin
                            remaining_d = preset_q;
                            state_d     = stop ? S_PAUSE : S_RUN;
                        end else begin
                            remaining_d = '0;
                            state_d     = S_DONE;
                        end
                    end else begin
                        if (tick) begin
                            remaining_d = remaining_q - One;
                        end
                        if (stop) begin
                            state_d = S_PAUSE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and registered outputs, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            preset_q    <= '0;
            remaining_q <= '0;
            expired_q   <= 1'b0;
            running_q   <= 1'b0;
            paused_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            preset_q    <= preset_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
            running_q   <= (state_d == S_RUN);
            paused_q    <= (state_d == S_PAUSE);
            done_q      <= (state_d == S_DONE);
        end
    end

    assign remaining = remaining_q;
    assign running   = running_q;
    assign paused    = paused_q;
    assign done      = done_q;
    assign expired   = expired_q;

endmodule
